// File: rtl/vc_input_unit.sv
// ---------------------------------------------------------------------------
// vc_input_unit
//
// Router input port with one circular flit FIFO and one packet-tracking FSM
// per virtual channel. Each VC requests the switch while it holds a routable
// packet. One flit per cycle is popped: either the lowest-index granted VC or,
// when nothing is granted, a stray non-head flit sitting at the front of an
// idle VC. Popped flits leave through a registered output stage and each pop
// returns one credit upstream on the following cycle.
//
// Parameters
//   FLIT_SIZE : flit width; the top two bits carry the flit type
//   NUM_VC    : number of virtual channels (2..8)
//   VC_DEPTH  : flits per VC buffer (power of two, >= 2)
//
// Ports
//   clk            : clock, all state changes on the rising edge
//   reset_n        : asynchronous active-low reset
//   i_flit_valid   : upstream flit strobe
//   i_flit         : upstream flit
//   i_flit_vc      : target VC of i_flit
//   i_switch_gnt   : switch allocator grant, one bit per VC
//   o_switch_req   : per-VC switch request
//   o_flit_valid   : registered flit strobe to the crossbar
//   o_flit         : flit to the crossbar (holds when o_flit_valid is low)
//   o_flit_vc      : VC of o_flit
//   o_credit_valid : one-cycle credit return pulse
//   o_credit_vc    : VC whose buffer slot was freed
//   o_vc_state     : per-VC FSM state, VC v in bits [2v+1:2v]
//   o_overflow     : sticky, a flit arrived for a full VC and was dropped
//   o_proto_err    : sticky, a non-head flit was discarded from an idle VC
// ---------------------------------------------------------------------------
module vc_input_unit #(
  parameter int FLIT_SIZE = 34,
  parameter int NUM_VC    = 2,
  parameter int VC_DEPTH  = 4,
  localparam int VC_W     = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_flit_valid,
  input  logic [FLIT_SIZE-1:0] i_flit,
  input  logic [VC_W-1:0]      i_flit_vc,
  input  logic [NUM_VC-1:0]    i_switch_gnt,
  output logic [NUM_VC-1:0]    o_switch_req,
  output logic                 o_flit_valid,
  output logic [FLIT_SIZE-1:0] o_flit,
  output logic [VC_W-1:0]      o_flit_vc,
  output logic                 o_credit_valid,
  output logic [VC_W-1:0]      o_credit_vc,
  output logic [2*NUM_VC-1:0]  o_vc_state,
  output logic                 o_overflow,
  output logic                 o_proto_err
);

  localparam int PTR_W = $clog2(VC_DEPTH);
  localparam int CNT_W = $clog2(VC_DEPTH + 1);

  // Flit type encodings (BODY is 2'b00; it is recognised as "bit 1 clear").
  localparam logic [1:0] FT_HEAD      = 2'b10;
  localparam logic [1:0] FT_TAIL      = 2'b01;
  localparam logic [1:0] FT_HEAD_TAIL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ACTIVE = 2'd2
  } vc_state_e;

  // Buffer storage carries data only and is never reset.
  logic [FLIT_SIZE-1:0] mem_q    [NUM_VC][VC_DEPTH];

  logic [PTR_W-1:0]     wr_ptr_q [NUM_VC];
  logic [PTR_W-1:0]     wr_ptr_d [NUM_VC];
  logic [PTR_W-1:0]     rd_ptr_q [NUM_VC];
  logic [PTR_W-1:0]     rd_ptr_d [NUM_VC];
  logic [CNT_W-1:0]     cnt_q    [NUM_VC];
  logic [CNT_W-1:0]     cnt_d    [NUM_VC];
  vc_state_e            state_q  [NUM_VC];
  vc_state_e            state_d  [NUM_VC];

  logic [FLIT_SIZE-1:0] head_flit [NUM_VC];
  logic [1:0]           head_type [NUM_VC];

  logic [NUM_VC-1:0]    not_empty;
  logic [NUM_VC-1:0]    full;
  logic [NUM_VC-1:0]    wr_en;
  logic [NUM_VC-1:0]    switch_req;
  logic [NUM_VC-1:0]    disc_cand;
  logic [NUM_VC-1:0]    gnt_vld;
  logic [NUM_VC-1:0]    gnt_oh;
  logic [NUM_VC-1:0]    disc_oh;
  logic [NUM_VC-1:0]    pop_oh;
  logic                 gnt_any;
  logic                 pop_any;
  logic                 ovf_hit;
  logic                 perr_hit;
  logic [VC_W-1:0]      pop_vc;
  logic [FLIT_SIZE-1:0] pop_flit;

  logic                 flit_valid_q;
  logic [FLIT_SIZE-1:0] flit_q;
  logic [VC_W-1:0]      flit_vc_q;
  logic                 credit_valid_q;
  logic [VC_W-1:0]      credit_vc_q;
  logic                 overflow_q;
  logic                 proto_err_q;

  // Per-VC status: head of buffer, occupancy flags, request and write enables.
  // The full check uses the count before any pop this cycle, so a write into
  // a full VC is dropped even if that VC is popped at the same edge.
  always_comb begin
    ovf_hit = 1'b0;
    for (int v = 0; v < NUM_VC; v++) begin
      head_flit[v]  = mem_q[v][rd_ptr_q[v]];
      head_type[v]  = head_flit[v][FLIT_SIZE-1 -: 2];
      not_empty[v]  = (cnt_q[v] != '0);
      full[v]       = (cnt_q[v] == CNT_W'(VC_DEPTH));
      switch_req[v] = (state_q[v] == ST_REQ) ||
                      ((state_q[v] == ST_ACTIVE) && not_empty[v]);
      // BODY (00) and TAIL (01) both have bit 1 clear.
      disc_cand[v]  = (state_q[v] == ST_IDLE) && not_empty[v] && !head_type[v][1];
      wr_en[v]      = i_flit_valid && (i_flit_vc == VC_W'(v)) && !full[v];
      if (i_flit_valid && (i_flit_vc == VC_W'(v)) && full[v]) begin
        ovf_hit = 1'b1;
      end
    end
  end

  // Pop arbitration: only grants that meet an active request count, the
  // lowest such VC wins (x & -x isolates the lowest set bit), and an idle-VC
  // discard only uses the pop slot when no grant claimed it.
  always_comb begin
    gnt_vld  = i_switch_gnt & switch_req;
    gnt_oh   = gnt_vld & (~gnt_vld + NUM_VC'(1));
    disc_oh  = disc_cand & (~disc_cand + NUM_VC'(1));
    gnt_any  = |gnt_vld;
    pop_oh   = gnt_any ? gnt_oh : disc_oh;
    pop_any  = |pop_oh;
    perr_hit = !gnt_any && (|disc_oh);
    pop_vc   = '0;
    pop_flit = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      if (pop_oh[v]) begin
        pop_vc   = VC_W'(v);
        pop_flit = head_flit[v];
      end
    end
  end

  // Next-state for pointers, counts and the per-VC packet FSM. In REQ and
  // ACTIVE a pop can only come from a grant, so pop_oh marks a granted pop.
  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      wr_ptr_d[v] = wr_ptr_q[v] + PTR_W'(wr_en[v]);
      rd_ptr_d[v] = rd_ptr_q[v] + PTR_W'(pop_oh[v]);
      cnt_d[v]    = cnt_q[v] + CNT_W'(wr_en[v]) - CNT_W'(pop_oh[v]);
      state_d[v]  = state_q[v];
      case (state_q[v])
        ST_IDLE: begin
          if (not_empty[v] && ((head_type[v] == FT_HEAD) || (head_type[v] == FT_HEAD_TAIL))) begin
            state_d[v] = ST_REQ;
          end
        end
        ST_REQ: begin
          if (pop_oh[v]) begin
            state_d[v] = (head_type[v] == FT_HEAD_TAIL) ? ST_IDLE : ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (pop_oh[v] && (head_type[v] == FT_TAIL)) begin
            state_d[v] = ST_IDLE;
          end
        end
        default: state_d[v] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VC; v++) begin
      if (wr_en[v]) begin
        mem_q[v][wr_ptr_q[v]] <= i_flit;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int v = 0; v < NUM_VC; v++) begin
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
        cnt_q[v]    <= '0;
        state_q[v]  <= ST_IDLE;
      end
      flit_valid_q   <= 1'b0;
      flit_q         <= '0;
      flit_vc_q      <= '0;
      credit_valid_q <= 1'b0;
      credit_vc_q    <= '0;
      overflow_q     <= 1'b0;
      proto_err_q    <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        wr_ptr_q[v] <= wr_ptr_d[v];
        rd_ptr_q[v] <= rd_ptr_d[v];
        cnt_q[v]    <= cnt_d[v];
        state_q[v]  <= state_d[v];
      end
      // Output stage: flit and credit appear one cycle after the pop.
      flit_valid_q <= gnt_any;
      if (gnt_any) begin
        flit_q    <= pop_flit;
        flit_vc_q <= pop_vc;
      end
      credit_valid_q <= pop_any;
      if (pop_any) begin
        credit_vc_q <= pop_vc;
      end
      if (ovf_hit) begin
        overflow_q <= 1'b1;
      end
      if (perr_hit) begin
        proto_err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    o_vc_state = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      o_vc_state[2*v +: 2] = state_q[v];
    end
  end

  assign o_switch_req   = switch_req;
  assign o_flit_valid   = flit_valid_q;
  assign o_flit         = flit_q;
  assign o_flit_vc      = flit_vc_q;
  assign o_credit_valid = credit_valid_q;
  assign o_credit_vc    = credit_vc_q;
  assign o_overflow     = overflow_q;
  assign o_proto_err    = proto_err_q;

endmodule

// File: tb/tb_vc_input_unit.sv
// ---------------------------------------------------------------------------
// tb_vc_input_unit
//
// Self-checking bench for vc_input_unit (FLIT_SIZE=34, NUM_VC=2, VC_DEPTH=4).
// A queue-based reference model tracks the buffered flits and the packet
// phase of each VC and is compared against the DUT after every clock.
// A directed vector table, hand-written corner sequences and a random phase
// drive the stimulus.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vc_input_unit;

  localparam int FS    = 34;
  localparam int NV    = 2;
  localparam int DEPTH = 4;

  localparam logic [1:0] T_HEAD = 2'b10;
  localparam logic [1:0] T_BODY = 2'b00;
  localparam logic [1:0] T_TAIL = 2'b01;
  localparam logic [1:0] T_HT   = 2'b11;

  logic          clk          = 1'b0;
  logic          reset_n      = 1'b0;
  logic          i_flit_valid = 1'b0;
  logic [FS-1:0] i_flit       = '0;
  logic [0:0]    i_flit_vc    = '0;
  logic [NV-1:0] i_switch_gnt = '0;
  logic [NV-1:0] o_switch_req;
  logic          o_flit_valid;
  logic [FS-1:0] o_flit;
  logic [0:0]    o_flit_vc;
  logic          o_credit_valid;
  logic [0:0]    o_credit_vc;
  logic [2*NV-1:0] o_vc_state;
  logic          o_overflow;
  logic          o_proto_err;

  vc_input_unit #(.FLIT_SIZE(FS), .NUM_VC(NV), .VC_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_flit_valid   (i_flit_valid),
    .i_flit         (i_flit),
    .i_flit_vc      (i_flit_vc),
    .i_switch_gnt   (i_switch_gnt),
    .o_switch_req   (o_switch_req),
    .o_flit_valid   (o_flit_valid),
    .o_flit         (o_flit),
    .o_flit_vc      (o_flit_vc),
    .o_credit_valid (o_credit_valid),
    .o_credit_vc    (o_credit_vc),
    .o_vc_state     (o_vc_state),
    .o_overflow     (o_overflow),
    .o_proto_err    (o_proto_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [FS-1:0] mkf(input logic [1:0] t, input logic [31:0] d);
    return {t, d};
  endfunction

  // ---------------- reference model ----------------
  // Per VC: the flits currently held, and the packet phase
  // (0 = waiting for a head, 1 = head waiting for the switch, 2 = mid-packet).
  logic [FS-1:0] mq [NV][$];
  int            mph [NV];
  logic          m_fv, m_cv, m_ovf, m_perr;
  logic [FS-1:0] m_flit;
  logic [0:0]    m_fvc, m_cvc;

  function automatic logic mreq(input int v);
    return (mph[v] == 1) || (mph[v] == 2 && mq[v].size() != 0);
  endfunction

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      mq[v].delete();
      mph[v] = 0;
    end
    m_fv = 0; m_cv = 0; m_ovf = 0; m_perr = 0;
    m_flit = '0; m_fvc = '0; m_cvc = '0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    int g, d, p, wv;
    int nph [NV];
    logic [FS-1:0] hf;
    logic [1:0] ht;
    logic push;
    g = -1; d = -1; hf = '0; push = 0; wv = 0;
    for (int v = 0; v < NV; v++) begin
      nph[v] = mph[v];
      if (g < 0 && i_switch_gnt[v] && mreq(v)) g = v;
    end
    for (int v = 0; v < NV; v++) begin
      if (mph[v] == 0 && mq[v].size() > 0) begin
        if (mq[v][0][FS-1]) nph[v] = 1;
        else if (d < 0) d = v;
      end
    end
    if (g >= 0) begin
      hf = mq[g][0];
      ht = hf[FS-1:FS-2];
      if (mph[g] == 1) nph[g] = (ht == T_HT) ? 0 : 2;
      else if (ht == T_TAIL) nph[g] = 0;
    end
    p = (g >= 0) ? g : d;
    if (i_flit_valid) begin
      wv = int'(i_flit_vc);
      if (mq[wv].size() >= DEPTH) m_ovf = 1;
      else push = 1;
    end
    if (p >= 0) void'(mq[p].pop_front());
    if (push) mq[wv].push_back(i_flit);
    m_fv = (g >= 0);
    if (g >= 0) begin
      m_flit = hf;
      m_fvc  = 1'(g);
    end
    m_cv = (p >= 0);
    if (p >= 0) m_cvc = 1'(p);
    if (g < 0 && d >= 0) m_perr = 1;
    for (int v = 0; v < NV; v++) mph[v] = nph[v];
  endtask

  task automatic check_all();
    logic [NV-1:0]   er;
    logic [2*NV-1:0] es;
    for (int v = 0; v < NV; v++) begin
      er[v] = mreq(v);
      es[2*v +: 2] = 2'(mph[v]);
    end
    chk("mdl_switch_req",   64'(o_switch_req),   64'(er));
    chk("mdl_flit_valid",   64'(o_flit_valid),   64'(m_fv));
    chk("mdl_flit",         64'(o_flit),         64'(m_flit));
    chk("mdl_flit_vc",      64'(o_flit_vc),      64'(m_fvc));
    chk("mdl_credit_valid", 64'(o_credit_valid), 64'(m_cv));
    chk("mdl_credit_vc",    64'(o_credit_vc),    64'(m_cvc));
    chk("mdl_vc_state",     64'(o_vc_state),     64'(es));
    chk("mdl_overflow",     64'(o_overflow),     64'(m_ovf));
    chk("mdl_proto_err",    64'(o_proto_err),    64'(m_perr));
  endtask

  // Inputs are applied 1 ns after a rising edge; outputs are checked 1 ns
  // after the next rising edge.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(input logic vld, input logic [FS-1:0] f, input logic vc, input logic [NV-1:0] g);
    i_flit_valid = vld; i_flit = f; i_flit_vc = vc; i_switch_gnt = g;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive(1'b0, '0, 1'b0, '0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("rst_vc_state", 64'(o_vc_state), 64'(0));
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic          vld;
    logic [FS-1:0] flit;
    logic          vc;
    logic [NV-1:0] gnt;
    logic [NV-1:0] e_req;
    logic          e_fv;
    logic [FS-1:0] e_flit;
    logic          e_cv;
    logic [2*NV-1:0] e_st;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FS-1:0] hf, bf, tf;
    logic [FS-1:0] exp_q[$];
    int fv_cnt, cv_cnt, tail_seen;

    hf = mkf(T_HEAD, 32'h0000_00A0);
    bf = mkf(T_BODY, 32'h0000_00B1);
    tf = mkf(T_TAIL, 32'h0000_00C2);

    // Three-flit packet through VC0 with its grant held.
    tbl[0] = '{1'b1, hf,     1'b0, 2'b01, 2'b00, 1'b0, 34'h0, 1'b0, 4'b0000};
    tbl[1] = '{1'b1, bf,     1'b0, 2'b01, 2'b01, 1'b0, 34'h0, 1'b0, 4'b0001};
    tbl[2] = '{1'b1, tf,     1'b0, 2'b01, 2'b01, 1'b1, hf,    1'b1, 4'b0010};
    tbl[3] = '{1'b0, 34'h0,  1'b0, 2'b01, 2'b01, 1'b1, bf,    1'b1, 4'b0010};
    tbl[4] = '{1'b0, 34'h0,  1'b0, 2'b01, 2'b00, 1'b1, tf,    1'b1, 4'b0000};
    tbl[5] = '{1'b0, 34'h0,  1'b0, 2'b01, 2'b00, 1'b0, tf,    1'b0, 4'b0000};

    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i].vld, tbl[i].flit, tbl[i].vc, tbl[i].gnt);
      cycle();
      chk("tbl_req",       64'(o_switch_req),   64'(tbl[i].e_req));
      chk("tbl_fvalid",    64'(o_flit_valid),   64'(tbl[i].e_fv));
      chk("tbl_flit",      64'(o_flit),         64'(tbl[i].e_flit));
      chk("tbl_cvalid",    64'(o_credit_valid), 64'(tbl[i].e_cv));
      chk("tbl_cvc",       64'(o_credit_vc),    64'(0));
      chk("tbl_state",     64'(o_vc_state),     64'(tbl[i].e_st));
    end

    // Overflow: five flits into VC1 without a grant, the fifth is dropped.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, mkf((i == 0) ? T_HEAD : ((i == 4) ? T_TAIL : T_BODY), 32'h100 + 32'(i)), 1'b1, 2'b00);
      cycle();
      chk("ovf_flag", 64'(o_overflow), 64'((i == 4) ? 1 : 0));
    end
    drive(1'b0, '0, 1'b0, 2'b10);
    fv_cnt = 0; tail_seen = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (o_flit_valid) begin
        fv_cnt++;
        if (o_flit[FS-1:FS-2] == T_TAIL) tail_seen++;
      end
    end
    chk("ovf_drained", 64'(fv_cnt), 64'(4));
    chk("ovf_no_tail", 64'(tail_seen), 64'(0));
    chk("ovf_state",   64'(o_vc_state), 64'(4'b1000));
    chk("ovf_sticky",  64'(o_overflow), 64'(1));
    do_reset();
    chk("ovf_cleared", 64'(o_overflow), 64'(0));

    // Two HEAD_TAIL packets ready at once with both grants set.
    drive(1'b1, mkf(T_HT, 32'h37), 1'b0, 2'b00); cycle();
    drive(1'b1, mkf(T_HT, 32'h38), 1'b1, 2'b00); cycle();
    drive(1'b0, '0, 1'b0, 2'b00); cycle();
    chk("dual_req",    64'(o_switch_req), 64'(2'b11));
    chk("dual_st0",    64'(o_vc_state),   64'(4'b0101));
    drive(1'b0, '0, 1'b0, 2'b11); cycle();
    chk("dual_fv0",    64'(o_flit_valid), 64'(1));
    chk("dual_vc0",    64'(o_flit_vc),    64'(0));
    chk("dual_flit0",  64'(o_flit),       64'(mkf(T_HT, 32'h37)));
    chk("dual_st1",    64'(o_vc_state),   64'(4'b0100));
    cycle();
    chk("dual_fv1",    64'(o_flit_valid), 64'(1));
    chk("dual_vc1",    64'(o_flit_vc),    64'(1));
    chk("dual_flit1",  64'(o_flit),       64'(mkf(T_HT, 32'h38)));
    chk("dual_cvc1",   64'(o_credit_vc),  64'(1));
    chk("dual_st2",    64'(o_vc_state),   64'(0));
    drive(1'b0, '0, 1'b0, 2'b00); cycle();
    chk("dual_fv_end", 64'(o_flit_valid), 64'(0));

    // Stray BODY flit at the front of idle VC0.
    do_reset();
    drive(1'b1, mkf(T_BODY, 32'h55), 1'b0, 2'b01); cycle();
    chk("perr_pre",    64'(o_proto_err),    64'(0));
    drive(1'b0, '0, 1'b0, 2'b01); cycle();
    chk("perr_cv",     64'(o_credit_valid), 64'(1));
    chk("perr_cvc",    64'(o_credit_vc),    64'(0));
    chk("perr_flag",   64'(o_proto_err),    64'(1));
    chk("perr_req",    64'(o_switch_req),   64'(0));
    chk("perr_fv",     64'(o_flit_valid),   64'(0));
    cycle();
    chk("perr_cv_end", 64'(o_credit_valid), 64'(0));
    chk("perr_sticky", 64'(o_proto_err),    64'(1));

    // Pointer wrap: ten single-flit packets through VC0.
    do_reset();
    fv_cnt = 0; cv_cnt = 0;
    exp_q.delete();
    for (int k = 0; k < 10; k++) exp_q.push_back(mkf(T_HT, 32'h200 + 32'(k)));
    for (int k = 0; k < 24; k++) begin
      if (k % 2 == 0 && k < 20) drive(1'b1, mkf(T_HT, 32'h200 + 32'(k / 2)), 1'b0, 2'b01);
      else drive(1'b0, '0, 1'b0, 2'b01);
      cycle();
      if (o_credit_valid) cv_cnt++;
      if (o_flit_valid) begin
        fv_cnt++;
        if (exp_q.size() > 0) chk("wrap_flit", 64'(o_flit), 64'(exp_q.pop_front()));
        else chk("wrap_extra", 64'(o_flit_valid), 64'(0));
      end
    end
    chk("wrap_count",   64'(fv_cnt),     64'(10));
    chk("wrap_credits", 64'(cv_cnt),     64'(10));
    chk("wrap_ovf",     64'(o_overflow), 64'(0));
    chk("wrap_state",   64'(o_vc_state), 64'(0));

    // Reset asserted while VC0 is mid-packet holding two flits.
    do_reset();
    drive(1'b1, hf, 1'b0, 2'b00); cycle();
    drive(1'b1, bf, 1'b0, 2'b00); cycle();
    drive(1'b1, tf, 1'b0, 2'b00); cycle();
    drive(1'b0, '0, 1'b0, 2'b01); cycle();
    drive(1'b0, '0, 1'b0, 2'b00); cycle();
    chk("arst_pre_state", 64'(o_vc_state), 64'(4'b0010));
    chk("arst_pre_req",   64'(o_switch_req), 64'(2'b01));
    reset_n = 1'b0;
    #2;
    model_reset();
    check_all();
    chk("arst_req_zero", 64'(o_switch_req), 64'(0));
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cv_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (o_credit_valid) cv_cnt++;
    end
    chk("arst_no_credit", 64'(cv_cnt),     64'(0));
    chk("arst_state",     64'(o_vc_state), 64'(0));

    // Random traffic against the model, with one reset in the middle.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      int r;
      logic [1:0] t;
      r = int'($urandom_range(0, 9));
      t = (r < 3) ? T_HEAD : (r < 6) ? T_BODY : (r < 8) ? T_TAIL : T_HT;
      drive(($urandom_range(0, 9) < 6), mkf(t, $urandom), 1'($urandom_range(0, 1)),
            NV'($urandom_range(0, 3)));
      cycle();
      if (i == 300) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vc_input_unit.md
VC_INPUT_UNIT -- requirements
Module: vc_input_unit

Interface
REQ-001 Parameter FLIT_SIZE, default 34: flit width in bits; bits [FLIT_SIZE-1:FLIT_SIZE-2] carry the flit type (HEAD=2'b10, BODY=2'b00, TAIL=2'b01, HEAD_TAIL=2'b11).
REQ-002 Parameter NUM_VC, default 2: number of virtual channels, 2..8.
REQ-003 Parameter VC_DEPTH, default 4: flits per VC buffer, power of two, at least 2; VC_W = max(1, clog2(NUM_VC)).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 i_flit_valid  input  1  upstream flit strobe.
REQ-007 i_flit  input  FLIT_SIZE  upstream flit.
REQ-008 i_flit_vc  input  VC_W  target VC of i_flit.
REQ-009 i_switch_gnt  input  NUM_VC  switch allocator grant, one bit per VC.
REQ-010 o_switch_req  output  NUM_VC  per-VC switch request.
REQ-011 o_flit_valid  output  1  registered flit to crossbar.
REQ-012 o_flit  output  FLIT_SIZE  flit to crossbar.
REQ-013 o_flit_vc  output  VC_W  VC of o_flit.
REQ-014 o_credit_valid  output  1  one-cycle credit return pulse to upstream.
REQ-015 o_credit_vc  output  VC_W  VC whose buffer slot was freed.
REQ-016 o_vc_state  output  2*NUM_VC  per-VC FSM state, VC v in bits [2v+1:2v].
REQ-017 o_overflow  output  1  sticky flag: flit written to a full VC.
REQ-018 o_proto_err  output  1  sticky flag: non-head flit found at the front of an idle VC.

Function
REQ-019 Each VC shall have an independent circular FIFO of VC_DEPTH entries with wrapping read/write pointers and an occupancy count of clog2(VC_DEPTH+1) bits.
REQ-020 When i_flit_valid=1, i_flit shall be written to FIFO i_flit_vc; if that FIFO is full (checked on the pre-pop count), the flit shall be dropped and o_overflow set.
REQ-021 A simultaneous write and pop on the same non-full VC shall both take effect, leaving the count unchanged.
REQ-022 A written flit is not visible at the FIFO head until the cycle after the write; there is no bypass path.
REQ-023 Each VC FSM shall have three states: IDLE=2'd0, REQ=2'd1, ACTIVE=2'd2; 2'd3 is unused and shall return to IDLE.
REQ-024 IDLE: if the FIFO is non-empty and its head is HEAD or HEAD_TAIL, go to REQ; if the head is BODY or TAIL, discard it (pop plus credit) and set o_proto_err.
REQ-025 o_switch_req[v] shall be high in REQ, and in ACTIVE while FIFO v is non-empty; it shall be low otherwise.
REQ-026 A grant shall pop the granting VC only when o_switch_req[v]=1 in the same cycle; all other grants are ignored.
REQ-027 If more than one valid grant bit is set, only the lowest-index VC shall be served.
REQ-028 At most one pop per cycle: a granted pop takes priority over an IDLE discard, which waits for the next free cycle.
REQ-029 REQ plus a grant: pop the head; a HEAD_TAIL goes to IDLE, a HEAD goes to ACTIVE.
REQ-030 ACTIVE plus a grant: pop one flit; popping a TAIL goes to IDLE, otherwise the VC stays in ACTIVE.
REQ-031 A granted pop shall drive o_flit_valid=1, o_flit and o_flit_vc on the next cycle (one-cycle latency); o_flit holds its value when o_flit_valid=0.
REQ-032 Every pop, granted or discarded, shall pulse o_credit_valid for exactly one cycle, in the cycle after the pop, with o_credit_vc set to the popped VC.

Reset
REQ-033 While reset_n=0, and asynchronously on its assertion, the block shall clear all pointers and counts, set every VC FSM to IDLE, and drive o_switch_req=0, o_flit_valid=0, o_flit=0, o_flit_vc=0, o_credit_valid=0, o_credit_vc=0, o_vc_state=0, o_overflow=0 and o_proto_err=0.
REQ-034 Reset asserted mid-packet shall discard all buffered flits; no credit pulses shall be issued for them.

Verification
REQ-035 HEAD/BODY/TAIL written to VC0 on cycles 0-2, i_switch_gnt=2'b01 held -> o_switch_req[0] high at cycle 2; o_flit_valid at cycles 3,4,5 with flits in order; three credit pulses with vc 0; VC0 back in IDLE.
REQ-036 Five flits written to VC1 (VC_DEPTH=4) with no grant -> fifth flit dropped, o_overflow=1 until reset, count=4.
REQ-037 HEAD_TAIL in VC0 and VC1 together, i_switch_gnt=2'b11 -> VC0 served first, VC1 the next cycle; both return to IDLE.
REQ-038 BODY flit written to an idle VC0 -> discarded, one credit pulse with vc 0, o_proto_err=1, no switch request.
REQ-039 Pointer wrap: 10 single-flit HEAD_TAIL packets through VC0 with depth 4 -> all 10 emerged in order and 10 credits returned.
REQ-040 reset_n pulsed low while VC0 is in ACTIVE holding 2 flits -> all outputs 0 immediately; after release, no credit pulses and VC0 in IDLE.
